// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: length-prefixed, XOR-checksummed image
// written one byte per cycle; the CPU is held in reset until a verified load completes.
module imem_loader #(
  parameter int INSTR_MEM_SIZE = 256,
  parameter int AW             = $clog2(INSTR_MEM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [AW:0]   bytes_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] MEM_SIZE_L = 16'(INSTR_MEM_SIZE);

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_waddr_q, mem_waddr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    acc_q, acc_d;
  logic [15:0]   len_w;
  logic          xfer;

  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    len_w       = {len_hi_q, in_data};
    xfer        = in_valid && in_ready_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          // Only whole 32-bit words that fit in memory are accepted.
          if (len_w == 16'd0 || len_w > MEM_SIZE_L || len_w[1:0] != 2'b00) begin
            state_d = S_ERR;
          end else begin
            len_d   = len_w[AW:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = cnt_q[AW-1:0];
          mem_wdata_d = in_data;
          cnt_d       = cnt_q + 1'b1;
          acc_d       = acc_q ^ in_data;
          if (cnt_d == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (in_data == acc_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA)   || (state_d == S_CSUM);
    cpu_hold_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
    end
  end

  // Length and checksum registers are always written before they are read.
  always_ff @(posedge clk) begin
    len_hi_q <= len_hi_d;
    len_q    <= len_d;
    acc_q    <= acc_d;
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign bytes_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random and directed byte streams checked every cycle
// against a byte-position model of the load protocol.
module tb_imem_loader;
  localparam int SIZE = 256;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   bytes_loaded;

  imem_loader #(.INSTR_MEM_SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks position within the current stream rather than FSM states.
  bit         m_busy = 0, m_done = 0, m_err = 0, m_we = 0;
  int         m_pos = 0, m_len = 0, m_cnt = 0, m_addr = 0;
  logic [7:0] m_hi = 0, m_acc = 0, m_data = 0;
  bit         chk_en = 0;
  int         n_we = 0;
  logic [7:0] tb_mem [SIZE];

  always @(posedge clk) begin
    m_we = 0;
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_done = 0; m_err = 0; m_cnt = 0; m_acc = 0; m_pos = 0;
      end
    end else if (in_valid) begin
      if (m_pos == 0) m_hi = in_data;
      else if (m_pos == 1) begin
        m_len = m_hi * 256 + in_data;
        if (m_len == 0 || m_len > SIZE || (m_len % 4) != 0) begin
          m_busy = 0; m_err = 1;
        end
      end else if (m_pos < m_len + 2) begin
        m_we = 1; m_addr = m_pos - 2; m_data = in_data;
        m_cnt++; m_acc ^= in_data;
      end else begin
        m_busy = 0; m_done = (in_data == m_acc); m_err = !m_done;
      end
      m_pos++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_busy);
      chk("cpu_hold", cpu_hold, !m_done);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("bytes_loaded", bytes_loaded, m_cnt);
      chk("mem_we", mem_we, m_we);
      if (m_we) begin
        chk("mem_waddr", mem_waddr, m_addr);
        chk("mem_wdata", mem_wdata, m_data);
      end
      if (mem_we === 1'b1) begin
        n_we++;
        tb_mem[mem_waddr] = mem_wdata;
      end
    end
  end

  logic [7:0] strm[$];

  task automatic build(input int len, input bit bad);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    strm = {};
    strm.push_back(8'((len >> 8) & 255));
    strm.push_back(8'(len & 255));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      strm.push_back(b);
      x ^= b;
    end
    strm.push_back(bad ? ~x : x);
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit st);
    int budget = 200;
    bit sent = 0;
    while (!sent) begin
      @(negedge clk);
      start = st;
      if (int'($urandom_range(99)) < gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) sent = 1;
      end
      budget--;
      if (budget == 0 && !sent) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0h never accepted", b);
        sent = 1;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; n_we = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'($urandom_range(1));
      in_data = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run(input int gap, input int start_at);
    pulse_start();
    foreach (strm[i]) send(strm[i], gap, i == start_at);
    idle(3);
  endtask

  task automatic good_stream(input logic [7:0] csum);
    strm = '{8'h00, 8'h08, 8'h80, 8'h20, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    strm[10] = csum;
  endtask

  task automatic len_rule(input logic [15:0] l);
    pulse_start();
    send(l[15:8], 0, 0);
    send(l[7:0], 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lenrule_error", error, 1);
    chk("lenrule_in_ready", in_ready, 0);
    idle(2);
    chk("lenrule_writes", n_we, 0);
  endtask

  logic [7:0] payload [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    payload = '{8'h80, 8'h20, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_bytes", bytes_loaded, 0);
    rst = 1'b0;

    good_stream(8'hAA);
    run(0, -1);
    chk("good_done", done, 1);
    chk("good_cpu_hold", cpu_hold, 0);
    chk("good_bytes", bytes_loaded, 8);
    chk("good_writes", n_we, 8);
    for (int i = 0; i < 8; i++) chk("good_mem", tb_mem[i], payload[i]);

    good_stream(8'h55);
    run(0, -1);
    chk("badcs_error", error, 1);
    chk("badcs_done", done, 0);
    chk("badcs_cpu_hold", cpu_hold, 1);
    chk("badcs_writes", n_we, 8);

    len_rule(16'h0000);
    len_rule(16'h0006);
    len_rule(16'h0104);

    good_stream(8'hAA);
    run(50, -1);
    chk("bp_done", done, 1);
    chk("bp_writes", n_we, 8);

    pulse_start();
    for (int i = 0; i < 5; i++) send(strm[i], 0, 0);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; n_we = 0;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_cpu_hold", cpu_hold, 1);
    chk("midrst_bytes", bytes_loaded, 0);
    chk("midrst_mem_we", mem_we, 0);
    idle(5);
    chk("midrst_writes", n_we, 0);
    run(30, -1);
    chk("after_rst_done", done, 1);

    run(0, 5);
    chk("start_in_data_done", done, 1);
    chk("start_in_data_bytes", bytes_loaded, 8);

    pulse_start();
    chk("reload_cpu_hold", cpu_hold, 1);
    chk("reload_in_ready", in_ready, 1);
    chk("reload_done", done, 0);
    foreach (strm[i]) send(strm[i], 0, 0);
    idle(3);
    chk("reload_done2", done, 1);

    build(SIZE, 0);
    run(20, -1);
    chk("full_done", done, 1);
    chk("full_bytes", bytes_loaded, SIZE);
    chk("full_writes", n_we, SIZE);

    for (int t = 0; t < 20; t++) begin
      build(4 * int'($urandom_range(1, 16)), 1'($urandom_range(3) == 0));
      run(int'($urandom_range(60)), int'($urandom_range(40)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
